// File: rtl/pipeline_pkg.sv
// Shared types and constants for the RV32 pipeline stall/flush scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pipeline_pkg;

  // Default configuration
  localparam int MC_LATENCY_DEF  = 8;
  localparam int MEM_TIMEOUT_DEF = 64;

  // Counter widths cover the full legal parameter ranges (255 and 1023)
  localparam int MC_CNT_W  = 8;
  localparam int MEM_CNT_W = 10;

  // State encodings, kept as plain constants for legacy consumers of state_o
  localparam logic [1:0] ST_RUN      = 2'b00;
  localparam logic [1:0] ST_MC_WAIT  = 2'b01;
  localparam logic [1:0] ST_MEM_WAIT = 2'b10;

  typedef enum logic [1:0] {
    RUN      = ST_RUN,
    MC_WAIT  = ST_MC_WAIT,
    MEM_WAIT = ST_MEM_WAIT
  } ctrl_state_t;

  // Stall/flush enables for the PC and every pipeline register
  typedef struct packed {
    logic stall_pc;
    logic stall_f2d;
    logic stall_d2e;
    logic stall_e2m;
    logic stall_m2w;
    logic flush_f2d;
    logic flush_d2e;
    logic flush_e2m;
    logic flush_m2w;
  } stage_ctrl_t;

  localparam stage_ctrl_t CTRL_IDLE = '0;

  // A register that is held cannot also take a bubble: the hold wins.
  function automatic stage_ctrl_t resolve_ctrl(input stage_ctrl_t c);
    stage_ctrl_t r;
    r           = c;
    r.flush_f2d = c.flush_f2d & ~c.stall_f2d;
    r.flush_d2e = c.flush_d2e & ~c.stall_d2e;
    r.flush_e2m = c.flush_e2m & ~c.stall_e2m;
    r.flush_m2w = c.flush_m2w & ~c.stall_m2w;
    return r;
  endfunction

endpackage

// File: rtl/pipe_perf_cnt.sv
// Saturating event counter for pipeline performance monitoring.
// Latency: count visible one cycle after the counted event.
// Backpressure: none; clear has priority over increment. Built only with PIPELINE_CTRL_PERF_EN.
`ifdef PIPELINE_CTRL_PERF_EN
module pipe_perf_cnt #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] cnt_o
);

  logic [WIDTH-1:0] cnt_q;

  // Count events, sticking at all-ones instead of wrapping
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_q <= cnt_q + WIDTH'(1);
    end
  end

  assign cnt_o = cnt_q;

endmodule
`endif

// File: rtl/pipeline_ctrl.sv
// Central stall/flush scheduler for the 5-stage RV32 pipeline (memory wait > multi-cycle > redirect > load-use).
// Latency: all stall/flush enables are combinational from state, counters and inputs.
// Backpressure: a memory wait freezes every stage (including a running multi-cycle count). Optional perf counters: PIPELINE_CTRL_PERF_EN.
module pipeline_ctrl
  import pipeline_pkg::*;
#(
  parameter int ADDR_WIDTH  = 5,
  parameter int MC_LATENCY  = MC_LATENCY_DEF,
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [ADDR_WIDTH-1:0] rs1D_i,
  input  logic [ADDR_WIDTH-1:0] rs2D_i,
  input  logic [ADDR_WIDTH-1:0] rdE_i,
  input  logic                  result_srcE_i,
  input  logic                  pc_srcE_i,
  input  logic                  mc_startE_i,
  input  logic                  mem_reqM_i,
  input  logic                  mem_ackM_i,
  output logic                  stallPC_o,
  output logic                  stallFtoD_o,
  output logic                  stallDtoE_o,
  output logic                  stallEtoM_o,
  output logic                  stallMtoW_o,
  output logic                  flushFtoD_o,
  output logic                  flushDtoE_o,
  output logic                  flushEtoM_o,
  output logic                  flushMtoW_o,
  output logic                  mc_busy_o,
  output logic                  mem_err_o,
`ifdef PIPELINE_CTRL_PERF_EN
  input  logic                  perf_clr_i,
  output logic [31:0]           stall_cycles_o,
  output logic [31:0]           flush_events_o,
`endif
  output logic [1:0]            state_o
);

  ctrl_state_t          state_q, state_d;
  ctrl_state_t          ret_q, ret_d;       // state suspended by a memory wait
  ctrl_state_t          eff_state;          // state governing a non-waiting cycle
  logic [MC_CNT_W-1:0]  mc_cnt_q, mc_cnt_d;
  logic [MEM_CNT_W-1:0] mem_cnt_q, mem_cnt_d;
  logic                 mem_err_q, mem_err_d;
  logic                 load_use;
  logic                 mem_pending;
  logic                 mem_timeout;
  logic                 mem_stall;
  logic                 busy;
  stage_ctrl_t          ctrl_raw, ctrl;

  assign load_use = result_srcE_i && (rdE_i != '0) &&
                    ((rdE_i == rs1D_i) || (rdE_i == rs2D_i));

  // The timeout cycle lets the faulting access retire, so it is not a stall.
  assign mem_pending = mem_reqM_i && !mem_ackM_i;
  assign mem_timeout = mem_pending && (state_q == MEM_WAIT) &&
                       (mem_cnt_q == MEM_CNT_W'(MEM_TIMEOUT - 1));
  assign mem_stall   = mem_pending && !mem_timeout;

  // Once the memory wait ends, the cycle behaves as the suspended state (RUN on timeout)
  always_comb begin
    eff_state = state_q;
    if (state_q == MEM_WAIT) begin
      eff_state = mem_timeout ? RUN : ret_q;
    end
  end

  // Prioritised next-state and raw stall/flush selection
  always_comb begin
    state_d   = state_q;
    ret_d     = ret_q;
    mc_cnt_d  = mc_cnt_q;
    mem_cnt_d = mem_cnt_q;
    mem_err_d = mem_err_q | mem_timeout;
    ctrl_raw  = CTRL_IDLE;
    busy      = 1'b0;

    if (mem_stall) begin
      // Freeze everything; the multi-cycle counter holds its value
      ctrl_raw.stall_pc  = 1'b1;
      ctrl_raw.stall_f2d = 1'b1;
      ctrl_raw.stall_d2e = 1'b1;
      ctrl_raw.stall_e2m = 1'b1;
      ctrl_raw.stall_m2w = 1'b1;
      ctrl_raw.flush_m2w = 1'b1;
      state_d            = MEM_WAIT;
      if (state_q == MEM_WAIT) begin
        mem_cnt_d = mem_cnt_q + MEM_CNT_W'(1);
      end else begin
        ret_d     = state_q;
        mem_cnt_d = '0;
      end
      busy = (state_q == MC_WAIT) || ((state_q == MEM_WAIT) && (ret_q == MC_WAIT));
    end else begin
      state_d   = RUN;
      mem_cnt_d = '0;
      if ((eff_state == MC_WAIT) && (mc_cnt_q != '0)) begin
        // Multi-cycle op still occupying E: hold front end, bubble into M
        busy               = 1'b1;
        ctrl_raw.stall_pc  = 1'b1;
        ctrl_raw.stall_f2d = 1'b1;
        ctrl_raw.stall_d2e = 1'b1;
        ctrl_raw.flush_e2m = 1'b1;
        mc_cnt_d           = mc_cnt_q - MC_CNT_W'(1);
        state_d            = MC_WAIT;
      end else begin
        // RUN, or the final multi-cycle cycle where E advances; the op's own
        // mc_startE_i must not restart the unit on that final cycle.
        busy = (eff_state == MC_WAIT);
        if ((eff_state == RUN) && mc_startE_i) begin
          busy               = 1'b1;
          ctrl_raw.stall_pc  = 1'b1;
          ctrl_raw.stall_f2d = 1'b1;
          ctrl_raw.stall_d2e = 1'b1;
          ctrl_raw.flush_e2m = 1'b1;
          mc_cnt_d           = MC_CNT_W'(MC_LATENCY - 2);
          state_d            = MC_WAIT;
        end else if (pc_srcE_i) begin
          // Redirect discards F and D, including any load-use dependent
          ctrl_raw.flush_f2d = 1'b1;
          ctrl_raw.flush_d2e = 1'b1;
        end else if (load_use) begin
          ctrl_raw.stall_pc  = 1'b1;
          ctrl_raw.stall_f2d = 1'b1;
          ctrl_raw.flush_d2e = 1'b1;
        end
      end
    end
  end

  // State, counters and sticky error; reset abandons any wait immediately
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= RUN;
      ret_q     <= RUN;
      mc_cnt_q  <= '0;
      mem_cnt_q <= '0;
      mem_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ret_q     <= ret_d;
      mc_cnt_q  <= mc_cnt_d;
      mem_cnt_q <= mem_cnt_d;
      mem_err_q <= mem_err_d;
    end
  end

  // Outputs are forced quiet while reset is held
  always_comb begin
    ctrl = rst_i ? CTRL_IDLE : resolve_ctrl(ctrl_raw);
  end

  assign stallPC_o   = ctrl.stall_pc;
  assign stallFtoD_o = ctrl.stall_f2d;
  assign stallDtoE_o = ctrl.stall_d2e;
  assign stallEtoM_o = ctrl.stall_e2m;
  assign stallMtoW_o = ctrl.stall_m2w;
  assign flushFtoD_o = ctrl.flush_f2d;
  assign flushDtoE_o = ctrl.flush_d2e;
  assign flushEtoM_o = ctrl.flush_e2m;
  assign flushMtoW_o = ctrl.flush_m2w;
  assign mc_busy_o   = busy && !rst_i;
  assign mem_err_o   = mem_err_q;
  assign state_o     = state_q;

`ifdef PIPELINE_CTRL_PERF_EN
  pipe_perf_cnt #(.WIDTH(32)) u_stall_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (perf_clr_i),
    .inc_i (ctrl.stall_pc),
    .cnt_o (stall_cycles_o)
  );

  pipe_perf_cnt #(.WIDTH(32)) u_flush_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (perf_clr_i),
    .inc_i (ctrl.flush_f2d),
    .cnt_o (flush_events_o)
  );
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed hazard scenarios plus randomized traffic
// checked every cycle against an occupancy/wait-count model of the scheduling rules.
module tb_pipeline_ctrl;

  localparam int MC_LAT  = 8;
  localparam int MEM_TMO = 64;

  // Expected stall/flush vectors, order {stallPC,FtoD,DtoE,EtoM,MtoW, flushFtoD,DtoE,EtoM,MtoW}
  localparam logic [8:0] V_NONE = 9'b000000000;
  localparam logic [8:0] V_MEM  = 9'b111110000;
  localparam logic [8:0] V_MC   = 9'b111000010;
  localparam logic [8:0] V_BR   = 9'b000001100;
  localparam logic [8:0] V_LU   = 9'b110000100;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] rs1 = '0, rs2 = '0, rd = '0;
  logic       ld = 1'b0, br = 1'b0, mc = 1'b0, req = 1'b0, ack = 1'b0;
  logic       s_pc, s_fd, s_de, s_em, s_mw, f_fd, f_de, f_em, f_mw;
  logic       busy_o, err_o;
  logic [1:0] state_o;
`ifdef PIPELINE_CTRL_PERF_EN
  logic        perf_clr = 1'b0;
  logic [31:0] stall_cyc, flush_ev;
  int          m_stall_cnt, m_flush_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipeline_ctrl #(.ADDR_WIDTH(5), .MC_LATENCY(MC_LAT), .MEM_TIMEOUT(MEM_TMO)) dut (
    .clk_i(clk), .rst_i(rst),
    .rs1D_i(rs1), .rs2D_i(rs2), .rdE_i(rd),
    .result_srcE_i(ld), .pc_srcE_i(br), .mc_startE_i(mc),
    .mem_reqM_i(req), .mem_ackM_i(ack),
    .stallPC_o(s_pc), .stallFtoD_o(s_fd), .stallDtoE_o(s_de), .stallEtoM_o(s_em), .stallMtoW_o(s_mw),
    .flushFtoD_o(f_fd), .flushDtoE_o(f_de), .flushEtoM_o(f_em), .flushMtoW_o(f_mw),
    .mc_busy_o(busy_o), .mem_err_o(err_o),
`ifdef PIPELINE_CTRL_PERF_EN
    .perf_clr_i(perf_clr), .stall_cycles_o(stall_cyc), .flush_events_o(flush_ev),
`endif
    .state_o(state_o)
  );

  function automatic logic [8:0] vec();
    return {s_pc, s_fd, s_de, s_em, s_mw, f_fd, f_de, f_em, f_mw};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: drive inputs just after the edge, then settle before the caller samples
  task automatic cyc(input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] d,
                     input logic l, input logic b, input logic m, input logic q, input logic k);
    @(posedge clk);
    #1;
    rs1 = a1; rs2 = a2; rd = d; ld = l; br = b; mc = m; req = q; ack = k;
    #1;
  endtask

  task automatic idle();
    cyc(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    rs1 = '0; rs2 = '0; rd = '0; ld = 0; br = 0; mc = 0; req = 0; ack = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Model: remaining E occupancy of a multi-cycle op and consecutive memory wait cycles
  int m_mc_left = 0;
  int m_waited  = 0;
  bit m_err     = 1'b0;

  // Single compare process, sampling at the falling edge
  always @(negedge clk) begin
    logic [8:0] v;
    bit         b, lu, wait_req, tmo, exiting;
    int         st;
    if (rst) begin
      m_mc_left = 0;
      m_waited  = 0;
      m_err     = 1'b0;
`ifdef PIPELINE_CTRL_PERF_EN
      m_stall_cnt = 0;
      m_flush_cnt = 0;
`endif
    end else begin
      st = (m_waited > 0) ? 2 : ((m_mc_left > 0) ? 1 : 0);
      chk("state", 32'(state_o), 32'(st));
      chk("mem_err", 32'(err_o), 32'(m_err));
`ifdef PIPELINE_CTRL_PERF_EN
      chk("perf_stall", stall_cyc, 32'(m_stall_cnt));
      chk("perf_flush", flush_ev, 32'(m_flush_cnt));
`endif
      v        = V_NONE;
      b        = 1'b0;
      lu       = ld && (rd != 0) && ((rd == rs1) || (rd == rs2));
      wait_req = req && !ack;
      tmo      = wait_req && (m_waited == MEM_TMO);
      if (wait_req && !tmo) begin
        v = V_MEM;
        b = (m_mc_left > 0);
        m_waited++;
      end else begin
        m_waited = 0;
        if (tmo) begin
          m_err     = 1'b1;
          m_mc_left = 0;
        end
        if (m_mc_left > 1) begin
          v = V_MC;
          b = 1'b1;
          m_mc_left--;
        end else begin
          exiting   = (m_mc_left == 1);
          m_mc_left = 0;
          b         = exiting;
          if (!exiting && mc) begin
            v         = V_MC;
            b         = 1'b1;
            m_mc_left = MC_LAT - 1;
          end else if (br) begin
            v = V_BR;
          end else if (lu) begin
            v = V_LU;
          end
        end
      end
      chk("ctrl_vec", 32'(vec()), 32'(v));
      chk("mc_busy", 32'(busy_o), 32'(b));
`ifdef PIPELINE_CTRL_PERF_EN
      if (perf_clr) begin
        m_stall_cnt = 0;
        m_flush_cnt = 0;
      end else begin
        m_stall_cnt += int'(v[8]);
        m_flush_cnt += int'(v[3]);
      end
`endif
    end
  end

  initial begin
    int n_busy, n_de, n_em, n_stall, n_fd, exit_ok;

    // Reset state
    @(posedge clk);
    #1;
    chk("rst_state", 32'(state_o), 32'd0);
    chk("rst_vec", 32'(vec()), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_err", 32'(err_o), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Load-use, then the same pattern targeting x0
    cyc(5'd5, 5'd9, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("lu_vec", 32'(vec()), 32'(V_LU));
    cyc(5'd0, 5'd9, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("lu_x0_vec", 32'(vec()), 32'd0);
    idle();
    chk("lu_one_cycle", 32'(vec()), 32'd0);

    // Redirect together with load-use: flushes only
    cyc(5'd3, 5'd7, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("br_lu_vec", 32'(vec()), 32'(V_BR));

    // Multi-cycle op: occupies E for MC_LAT cycles, held for all but the last
    n_busy = 0; n_de = 0; n_em = 0;
    for (int i = 0; i < 12; i++) begin
      cyc(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, (i == 0), 1'b0, 1'b0);
      n_busy += int'(busy_o); n_de += int'(s_de); n_em += int'(f_em);
    end
    chk("mc_busy_cycles", 32'(n_busy), 32'd8);
    chk("mc_stallDtoE_cycles", 32'(n_de), 32'd7);
    chk("mc_flushEtoM_cycles", 32'(n_em), 32'd7);
    chk("mc_back_to_run", 32'(state_o), 32'd0);

    // Redirect held during the op: serviced only on the exit cycle
    n_fd = 0; exit_ok = 0;
    for (int i = 0; i < 8; i++) begin
      cyc(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, (i == 0), 1'b0, 1'b0);
      n_fd += int'(f_fd);
      if (i == 7 && f_fd && f_de && !s_pc && busy_o) exit_ok = 1;
    end
    chk("mc_br_flush_count", 32'(n_fd), 32'd1);
    chk("mc_br_on_exit", 32'(exit_ok), 32'd1);
    idle();

    // Memory wait: three cycles without ack, then ack
    n_stall = 0;
    for (int i = 0; i < 4; i++) begin
      cyc(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, (i == 3));
      n_stall += int'(s_pc);
      if (i == 1) chk("mem_wait_vec", 32'(vec()), 32'(V_MEM));
    end
    chk("mem_stall_cycles", 32'(n_stall), 32'd3);
    chk("mem_ack_no_stall", 32'(vec()), 32'd0);
    idle();

    // Memory wait inside a multi-cycle op: 4 frozen cycles extend occupancy to 12
    n_busy = 0;
    for (int i = 0; i < 16; i++) begin
      cyc(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, (i == 0), (i >= 3 && i <= 7), (i == 7));
      n_busy += int'(busy_o);
      if (i == 5) chk("mc_mem_state", 32'(state_o), 32'd2);
    end
    chk("mc_mem_busy_cycles", 32'(n_busy), 32'd12);

    // Timeout: MEM_TMO unacked wait cycles, then the access retires with the error set
    n_stall = 0;
    for (int i = 0; i < MEM_TMO + 1; i++) begin
      cyc(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      n_stall += int'(s_pc);
    end
    chk("tmo_stall_cycles", 32'(n_stall), 32'(MEM_TMO));
    idle();
    chk("tmo_err_set", 32'(err_o), 32'd1);
    chk("tmo_run", 32'(state_o), 32'd0);
    repeat (5) idle();
    chk("tmo_err_sticky", 32'(err_o), 32'd1);
    do_reset();
    #1;
    chk("err_cleared_by_rst", 32'(err_o), 32'd0);

    // Randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      cyc(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
          ($urandom_range(0, 2) == 0), ($urandom_range(0, 7) == 0), ($urandom_range(0, 11) == 0),
          ($urandom_range(0, 2) == 0), ($urandom_range(0, 1) == 0));
`ifdef PIPELINE_CTRL_PERF_EN
      perf_clr = (i == 2000);
`endif
    end
`ifdef PIPELINE_CTRL_PERF_EN
    perf_clr = 1'b0;
`endif

    // Asynchronous reset in the middle of a multi-cycle op
    idle();
    idle();
    cyc(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    idle();
    idle();
    chk("pre_rst_mc_state", 32'(state_o), 32'd1);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("async_rst_state", 32'(state_o), 32'd0);
    chk("async_rst_vec", 32'(vec()), 32'd0);
    chk("async_rst_busy", 32'(busy_o), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (3) idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
